// File: rtl/mult_pkg.sv
// Shared state encoding and default sizing for the shift-add multiplier sequencer.
// Consumed by mult_ctrl and mult_iter_cnt.
package mult_pkg;

    localparam int N_DEF  = 4;
    localparam int CW_DEF = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier sequencer: sync clear, enable, last-iteration flag.
// One-cycle update latency; no backpressure (driven purely by the FSM).
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CW'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Shift-add multiplier sequencer: clr, ld, then N x (ldp, shp+shb), then a one-cycle done pulse.
// Latency 2N+3 cycles start-to-done; MULT_CTRL_SKIP_ZERO_ADD_EN bypasses ADD for zero multiplier bits.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic qb0,
    output logic clr,
    output logic ld,
    output logic ldp,
    output logic shp,
    output logic shb,
    output logic busy,
    output logic done
);

    state_e state_q;
    state_e state_d;
    state_e iter_next;
    logic   cnt_last;
    logic   cnt_clr;
    logic   cnt_en;

    assign cnt_clr = (state_q == LOAD);
    assign cnt_en  = (state_q == SHIFT) && !cnt_last;

`ifdef MULT_CTRL_SKIP_ZERO_ADD_EN
    // qb0 already reflects the bit the coming iteration will consume.
    assign iter_next = qb0 ? ADD : SHIFT;
`else
    logic unused_qb0;
    assign unused_qb0 = qb0;
    assign iter_next  = ADD;
`endif

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? CLR : IDLE;
            CLR:     state_d = LOAD;
            LOAD:    state_d = iter_next;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = cnt_last ? DONE : iter_next;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clr     <= 1'b0;
            ld      <= 1'b0;
            ldp     <= 1'b0;
            shp     <= 1'b0;
            shb     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            clr     <= (state_d == CLR);
            ld      <= (state_d == LOAD);
            ldp     <= (state_d == ADD);
            shp     <= (state_d == SHIFT);
            shb     <= (state_d == SHIFT);
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

    mult_iter_cnt #(
        .N  (N),
        .CW (CW)
    ) u_iter_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_o (cnt_last)
    );

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural 4-bit shift-add datapath hung off the strobes.
module tb_mult_ctrl;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic qb0;
    logic clr, ld, ldp, shp, shb, busy, done;
    logic [6:0] outs;

    always #5 clk = ~clk;

    mult_ctrl #(.N(4), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .qb0   (qb0),
        .clr   (clr),
        .ld    (ld),
        .ldp   (ldp),
        .shp   (shp),
        .shb   (shb),
        .busy  (busy),
        .done  (done)
    );

    assign outs = {clr, ld, ldp, shp, shb, busy, done};

    // Datapath model: multiplicand a_q, multiplier b_q, product p_q with carry bit 8.
    logic [3:0] a_in = 4'd0, b_in = 4'd0, a_q, b_q;
    logic [8:0] p_q;

    always @(posedge clk) begin
        if (clr) p_q <= 9'd0;
        if (ld) begin
            a_q <= a_in;
            b_q <= b_in;
        end
        if (ldp) p_q[8:4] <= {1'b0, p_q[7:4]} + {1'b0, (b_q[0] ? a_q : 4'd0)};
        if (shp) p_q <= p_q >> 1;
        if (shb) b_q <= b_q >> 1;
    end

    // qb0 presents the bit that will sit in b_q[0] after the current edge.
    assign qb0 = ld ? b_in[0] : (shb ? b_q[1] : b_q[0]);

    int checks = 0;
    int errors = 0;
    logic [6:0] tr [0:31];
    int done_list [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edge 0 samples start; trace index c is the cycle after edge c-1.
    task automatic run(input logic [3:0] a, input logic [3:0] b, input bit hold,
                       input int poke1, input int poke2, input int ncyc);
        a_in = a;
        b_in = b;
        start = 1'b1;
        done_list.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            tr[c] = outs;
            if (done) done_list.push_back(c);
            start = hold || (c == poke1) || (c == poke2);
        end
        start = 1'b0;
    endtask

    typedef struct {
        int         cyc;
        logic [6:0] exp;
    } trace_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        int         done_off;
        int         done_on;
    } prod_t;

    trace_t tvec [12];
    prod_t  pvec [4];

    initial begin
        // {clr, ld, ldp, shp, shb, busy, done}
        tvec[0]  = '{1,  7'b1000010};
        tvec[1]  = '{2,  7'b0100010};
        tvec[2]  = '{3,  7'b0010010};
        tvec[3]  = '{4,  7'b0001110};
        tvec[4]  = '{5,  7'b0010010};
        tvec[5]  = '{6,  7'b0001110};
        tvec[6]  = '{7,  7'b0010010};
        tvec[7]  = '{8,  7'b0001110};
        tvec[8]  = '{9,  7'b0010010};
        tvec[9]  = '{10, 7'b0001110};
        tvec[10] = '{11, 7'b0000011};
        tvec[11] = '{12, 7'b0000000};

        pvec[0] = '{4'd13, 4'd11, 8'h8F, 11, 10};
        pvec[1] = '{4'd15, 4'd15, 8'hE1, 11, 11};
        pvec[2] = '{4'd0,  4'd5,  8'h00, 11, 9};
        pvec[3] = '{4'd9,  4'd6,  8'h36, 11, 9};

        // Reset state
        #2;
        chk("reset_outs", 32'(outs), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 32'(outs), 32'h0);

        // Strobe trace for an all-ones multiplier (identical with or without the skip feature)
        run(4'd15, 4'd15, 1'b0, 0, 0, 13);
        for (int i = 0; i < 12; i++)
            chk($sformatf("trace_c%0d", tvec[i].cyc), 32'(tr[tvec[i].cyc]), 32'(tvec[i].exp));

        // Products and done timing
        for (int i = 0; i < 4; i++) begin
            run(pvec[i].a, pvec[i].b, 1'b0, 0, 0, 13);
            chk($sformatf("prod_%0dx%0d", pvec[i].a, pvec[i].b), 32'(p_q[7:0]), 32'(pvec[i].p));
            chk("done_count", 32'(done_list.size()), 32'd1);
`ifdef MULT_CTRL_SKIP_ZERO_ADD_EN
            chk("done_cycle", 32'(done_list[0]), 32'(pvec[i].done_on));
`else
            chk("done_cycle", 32'(done_list[0]), 32'(pvec[i].done_off));
`endif
        end

        // start pokes while busy are ignored
        run(4'd15, 4'd15, 1'b0, 3, 7, 13);
        for (int i = 0; i < 12; i++)
            chk($sformatf("poke_c%0d", tvec[i].cyc), 32'(tr[tvec[i].cyc]), 32'(tvec[i].exp));
        chk("poke_done_count", 32'(done_list.size()), 32'd1);

        // start held high: back-to-back with one IDLE cycle
        run(4'd15, 4'd15, 1'b1, 0, 0, 24);
        chk("held_done_count", 32'(done_list.size()), 32'd2);
        chk("held_done0", 32'(done_list[0]), 32'd11);
        chk("held_done1", 32'(done_list[1]), 32'd23);
        chk("held_idle_c12", 32'(tr[12]), 32'h0);
        chk("held_clr_c13", 32'(tr[13]), 32'(7'b1000010));
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in SHIFT (cycle 6)
        a_in = 4'd15;
        b_in = 4'd15;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_shift", 32'(outs), 32'(7'b0001110));
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 14; c++) begin
                @(posedge clk);
                #1;
                if (outs != 7'b0) seen++;
            end
            chk("post_reset_quiet", 32'(seen), 32'd0);
        end

        // Illegal state encoding recovers to IDLE with outputs low
        a_in = 4'd15;
        b_in = 4'd15;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        force dut.state_q = state_e'(3'b111);
        #1;
        release dut.state_q;
        @(posedge clk);
        #1;
        chk("illegal_outs", 32'(outs), 32'h0);
        chk("illegal_state", 32'(dut.state_q), 32'(IDLE));
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                if (outs != 7'b0) seen++;
            end
            chk("illegal_quiet", 32'(seen), 32'd0);
        end

`ifdef MULT_CTRL_SKIP_ZERO_ADD_EN
        // Multiplier 0101: ADD only in iterations 0 and 2 (cycles 3 and 6)
        begin
            logic [15:0] ldp_mask;
            run(4'd7, 4'd5, 1'b0, 0, 0, 12);
            ldp_mask = '0;
            for (int c = 1; c <= 12; c++) ldp_mask[c] = tr[c][4];
            chk("skip_0101_ldp", 32'(ldp_mask), 32'h0048);
            chk("skip_0101_done", 32'(done_list[0]), 32'd9);
            chk("skip_0101_prod", 32'(p_q[7:0]), 32'h23);
            run(4'd9, 4'd0, 1'b0, 0, 0, 12);
            ldp_mask = '0;
            for (int c = 1; c <= 12; c++) ldp_mask[c] = tr[c][4];
            chk("skip_zero_ldp", 32'(ldp_mask), 32'h0);
            chk("skip_zero_done", 32'(done_list[0]), 32'd7);
            chk("skip_zero_prod", 32'(p_q[7:0]), 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
